memory_scheduler: RTL and testbench

- Shares the single external memory port between N requesters: fetch instruction port, execute data port, and optional debug/DMA masters.
- Arbitration is round-robin. The block registers the winning request, sequences one memory transaction at a time, and returns the response to the winner.
- Includes a ready-timeout watchdog that reports a bus error instead of hanging the pipeline.
- Sits between the stage mem ports and the top-level memory_* pins; it replaces the two-master arbiter in multi-master builds.

---
 rtl/memory_scheduler_pkg.sv | 22 ++
 rtl/memory_scheduler_pick.sv | 39 +++
 rtl/memory_scheduler.sv | 142 ++++++++++++++
 tb/tb_memory_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_scheduler_pkg.sv
// Shared types for the multi-master memory scheduler: FSM states, the latched
// request record and the memory bus field widths.
package memory_scheduler_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_type;

endpackage

// File: rtl/memory_scheduler_pick.sv
// Rotating-priority picker: returns the first set valid bit at or above i_ptr,
// wrapping from NREQ-1 back to 0.
module memory_scheduler_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_gnt,
    output logic             o_any
);

    localparam logic [PTR_W:0] NREQ_W = (PTR_W + 1)'(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [PTR_W-1:0]  w_off;
    logic [PTR_W:0]    w_sum;
    logic [PTR_W:0]    w_wrap;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_dbl = {i_valid, i_valid} >> i_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PTR_W'(k);
            end
        end
    end

    assign w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
    assign w_wrap = w_sum - NREQ_W;
    assign o_gnt  = (w_sum >= NREQ_W) ? w_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];
    assign o_any  = |i_valid;

endmodule

// File: rtl/memory_scheduler.sv
// Round-robin scheduler sharing one memory port among NREQ requesters, one
// transaction at a time, with a ready-timeout watchdog that reports a bus error.
module memory_scheduler
    import memory_scheduler_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int TIMEOUT    = 1024,
    parameter int FIXED_PRIO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_instr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ*STRB_W-1:0]   req_wstrb,
    output logic [NREQ-1:0]          req_ready,
    output logic                     req_error,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     memory_valid,
    output logic                     memory_instr,
    output logic [ADDR_W-1:0]        memory_addr,
    output logic [DATA_W-1:0]        memory_wdata,
    output logic [STRB_W-1:0]        memory_wstrb,
    input  logic [DATA_W-1:0]        memory_rdata,
    input  logic                     memory_ready
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

    sched_state_e      r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_gnt;
    logic [CNT_W-1:0]  r_cnt;
    mem_req_type       r_req;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_mem_valid;
    logic [NREQ-1:0]   r_req_ready;

    logic [PTR_W-1:0]  w_scan_ptr;
    logic [PTR_W-1:0]  w_gnt;
    logic              w_any;
    logic [PTR_W-1:0]  w_ptr_next;
    logic              w_timeout;
    mem_req_type       w_sel;

    assign w_scan_ptr = (FIXED_PRIO != 0) ? '0 : r_ptr;

    memory_scheduler_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (w_scan_ptr),
        .o_gnt   (w_gnt),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == PTR_W'(i)) begin
                w_sel.instr = req_instr[i];
                w_sel.addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel.wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel.wstrb = req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    assign w_ptr_next = (r_gnt == PTR_W'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
    // TIMEOUT = 0 disables the watchdog; the counter then free-runs harmlessly.
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_mem_valid <= 1'b0;
            r_req_ready <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_gnt;
                        r_req       <= w_sel;
                        r_cnt       <= '0;
                        r_mem_valid <= 1'b1;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (memory_ready) begin
                        r_rdata     <= (r_req.wstrb == '0) ? memory_rdata : '0;
                        r_err       <= 1'b0;
                        r_mem_valid <= 1'b0;
                        r_req_ready <= ONE_HOT0 << r_gnt;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rdata     <= '0;
                        r_err       <= 1'b1;
                        r_mem_valid <= 1'b0;
                        r_req_ready <= ONE_HOT0 << r_gnt;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // Response fields are only meaningful alongside the ready pulse.
                    r_req_ready <= '0;
                    r_rdata     <= '0;
                    r_err       <= 1'b0;
                    r_ptr       <= w_ptr_next;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign req_error    = r_err;
    assign req_rdata    = r_rdata;
    assign memory_valid = r_mem_valid;
    assign memory_instr = r_req.instr;
    assign memory_addr  = r_req.addr;
    assign memory_wdata = r_req.wdata;
    assign memory_wstrb = r_req.wstrb;

endmodule

// File: tb/tb_memory_scheduler.sv
// Bench for memory_scheduler: a round-robin instance (NREQ=2, TIMEOUT=16) and a
// fixed-priority instance (NREQ=4, watchdog disabled) against a reference model.
module tb_memory_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance
    logic        rst_a;
    logic [1:0]  a_valid, a_instr, a_ready;
    logic [63:0] a_addr, a_wdata;
    logic [7:0]  a_wstrb;
    logic        a_err, a_mv, a_minstr, a_mready;
    logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
    logic [3:0]  a_mwstrb;

    // Fixed-priority instance
    logic         rst_b;
    logic [3:0]   b_valid, b_instr, b_ready;
    logic [127:0] b_addr, b_wdata;
    logic [15:0]  b_wstrb;
    logic         b_err, b_mv, b_minstr, b_mready;
    logic [31:0]  b_rdata, b_maddr, b_mwdata, b_mrdata;
    logic [3:0]   b_mwstrb;

    memory_scheduler #(.NREQ(2), .TIMEOUT(16), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst(rst_a),
        .req_valid(a_valid), .req_instr(a_instr), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_wstrb(a_wstrb),
        .req_ready(a_ready), .req_error(a_err), .req_rdata(a_rdata),
        .memory_valid(a_mv), .memory_instr(a_minstr), .memory_addr(a_maddr),
        .memory_wdata(a_mwdata), .memory_wstrb(a_mwstrb),
        .memory_rdata(a_mrdata), .memory_ready(a_mready)
    );

    memory_scheduler #(.NREQ(4), .TIMEOUT(0), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst(rst_b),
        .req_valid(b_valid), .req_instr(b_instr), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_wstrb(b_wstrb),
        .req_ready(b_ready), .req_error(b_err), .req_rdata(b_rdata),
        .memory_valid(b_mv), .memory_instr(b_minstr), .memory_addr(b_maddr),
        .memory_wdata(b_mwdata), .memory_wstrb(b_mwstrb),
        .memory_rdata(b_mrdata), .memory_ready(b_mready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state for instance A
    int          ptr_m, exp_g, busy_n, lat, mv_cycles, served_total;
    bit          exp_resp, prev_idle, prev_mv, granted, hang, rnd_mode, hold_all;
    logic [31:0] exp_rdata, cap_addr, cap_wdata;
    logic        exp_err, cap_instr;
    logic [3:0]  cap_wstrb;
    int          order_q[$];

    // Model state for instance B
    int b_exp_g, b_grants, b_last;
    bit b_prev_mv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requesting index scanning upward from p, wrapping at n-1.
    function automatic int rr_pick(input logic [3:0] m, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (p + k) % n;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req_a(input int i, input logic ins, input logic [31:0] ad,
                             input logic [31:0] wd, input logic [3:0] ws);
        a_valid[i]         = 1'b1;
        a_instr[i]         = ins;
        a_addr[i*32 +: 32] = ad;
        a_wdata[i*32 +: 32] = wd;
        a_wstrb[i*4 +: 4]  = ws;
    endtask

    task automatic reset_model();
        ptr_m = 0; exp_resp = 0; prev_idle = 1; prev_mv = 0; granted = 0; busy_n = 0;
    endtask

    task automatic step_a();
        logic [1:0] seen;
        @(negedge clk); #1;
        seen = a_valid;
        chk("a_excl", a_mv & (|a_ready), 0);
        if (exp_resp) begin
            chk("a_ready", a_ready, 64'd1 << exp_g);
            chk("a_rdata", a_rdata, exp_rdata);
            chk("a_err", a_err, exp_err);
            ptr_m = (exp_g + 1) % 2;
            order_q.push_back(exp_g);
            served_total++;
            exp_resp = 0;
            granted = 0;
            a_valid[exp_g] = hold_all;
        end else begin
            chk("a_noready", a_ready, 0);
            chk("a_err_idle", a_err, 0);
        end
        if (prev_idle) chk("a_grant_lat", a_mv, |seen);
        if (a_mv && !prev_mv) begin
            chk("a_busy_entry", prev_idle, 1);
            exp_g = rr_pick({2'b00, seen}, ptr_m, 2);
            if (exp_g < 0) exp_g = 0;
            cap_instr = a_instr[exp_g];
            cap_addr  = a_addr[exp_g*32 +: 32];
            cap_wdata = a_wdata[exp_g*32 +: 32];
            cap_wstrb = a_wstrb[exp_g*4 +: 4];
            busy_n = 0;
            granted = 1;
            if (rnd_mode) lat = $urandom_range(0, 3);
        end
        if (a_mv) begin
            mv_cycles++;
            busy_n++;
            chk("a_minstr", a_minstr, cap_instr);
            chk("a_maddr", a_maddr, cap_addr);
            chk("a_mwdata", a_mwdata, cap_wdata);
            chk("a_mwstrb", a_mwstrb, cap_wstrb);
            a_mrdata = $urandom;
            if (!hang && busy_n == lat + 1) begin
                a_mready  = 1'b1;
                exp_rdata = (cap_wstrb == 4'd0) ? a_mrdata : 32'd0;
                exp_err   = 1'b0;
                exp_resp  = 1;
            end else begin
                a_mready = 1'b0;
                if (busy_n == 16) begin
                    exp_rdata = 32'd0;
                    exp_err   = 1'b1;
                    exp_resp  = 1;
                end
            end
            // A granted requester changing its fields must not disturb the bus.
            if (rnd_mode && $urandom_range(0, 3) == 0)
                set_req_a(exp_g, 1'($urandom), $urandom, $urandom, 4'($urandom));
        end else begin
            a_mready = 1'($urandom_range(0, 1));
            a_mrdata = $urandom;
        end
        if (rnd_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (!a_valid[i] && $urandom_range(0, 2) == 0)
                    set_req_a(i, 1'($urandom), $urandom, $urandom,
                              ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom));
                else if (a_valid[i] && !(granted && exp_g == i) && $urandom_range(0, 15) == 0)
                    a_valid[i] = 1'b0;
            end
        end
        prev_idle = !a_mv && (a_ready == 2'b00);
        prev_mv   = a_mv;
    endtask

    task automatic run_a(input int target, input int maxs);
        int start;
        start = served_total;
        for (int s = 0; s < maxs && (served_total - start) < target; s++) step_a();
        chk("a_txn_bound", served_total - start, target);
    endtask

    task automatic step_b(input bit give);
        @(negedge clk); #1;
        chk("b_excl", b_mv & (|b_ready), 0);
        if (b_mv && !b_prev_mv) b_exp_g = rr_pick(b_valid, 0, 4);
        if (|b_ready) begin
            chk("b_ready", b_ready, 64'd1 << b_exp_g);
            chk("b_err", b_err, 0);
            b_grants++;
            b_last = b_exp_g;
        end
        if (b_mv) begin
            chk("b_maddr", b_maddr, 32'h1000 + 4 * b_exp_g);
            b_mready = give;
        end else begin
            b_mready = 1'b0;
        end
        b_mrdata  = $urandom;
        b_prev_mv = b_mv;
    endtask

    initial begin
        int base, g0;
        rst_a = 1'b0; rst_b = 1'b0;
        a_valid = '0; a_instr = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        a_mready = 1'b0; a_mrdata = '0;
        b_valid = '0; b_instr = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        b_mready = 1'b0; b_mrdata = '0;
        hang = 0; rnd_mode = 0; hold_all = 0; lat = 0; mv_cycles = 0; served_total = 0;
        b_grants = 0; b_last = -1; b_exp_g = 0; b_prev_mv = 0;
        reset_model();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_mv", a_mv, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_maddr", a_maddr, 0);
        chk("rst_b_mv", b_mv, 0);
        chk("rst_b_ready", b_ready, 0);
        rst_a = 1'b1; rst_b = 1'b1;

        // Single read, two wait cycles
        set_req_a(0, 1'b0, 32'h100, 32'h0, 4'd0);
        lat = 2;
        run_a(1, 20);
        chk("t1_winner", order_q[$], 0);

        // Contention with both requesters held high, zero-wait memory
        hold_all = 1; lat = 0;
        set_req_a(0, 1'b1, 32'h200, 32'h0, 4'd0);
        set_req_a(1, 1'b0, 32'h300, 32'hAA55AA55, 4'hF);
        base = order_q.size();
        run_a(4, 40);
        for (int k = 1; k < 4; k++)
            chk("t2_alternate", order_q[base + k] != order_q[base + k - 1], 1);
        hold_all = 0;
        a_valid = '0;
        step_a();

        // Write forwarding through five wait cycles
        set_req_a(1, 1'b0, 32'h2004, 32'h12345678, 4'b0011);
        lat = 5; mv_cycles = 0;
        run_a(1, 20);
        chk("t3_winner", order_q[$], 1);
        chk("t3_busy_len", mv_cycles, 6);

        // Watchdog timeout, then a normal transaction
        hang = 1; mv_cycles = 0;
        set_req_a(0, 1'b1, 32'h40, 32'h0, 4'd0);
        run_a(1, 40);
        chk("t4_busy_len", mv_cycles, 16);
        hang = 0; lat = 1;
        set_req_a(0, 1'b0, 32'h44, 32'h0, 4'd0);
        run_a(1, 20);

        // Reset during a wait state of requester 1
        set_req_a(1, 1'b0, 32'h3000, 32'h0, 4'd0);
        lat = 10;
        for (int s = 0; s < 12; s++) begin
            step_a();
            if (busy_n >= 3) break;
        end
        chk("t5_in_busy", a_mv, 1);
        #2 rst_a = 1'b0;
        #1;
        chk("t5_rst_mv", a_mv, 0);
        chk("t5_rst_ready", a_ready, 0);
        chk("t5_rst_err", a_err, 0);
        chk("t5_rst_rdata", a_rdata, 0);
        chk("t5_rst_minstr", a_minstr, 0);
        chk("t5_rst_maddr", a_maddr, 0);
        chk("t5_rst_mwdata", a_mwdata, 0);
        chk("t5_rst_mwstrb", a_mwstrb, 0);
        reset_model();
        lat = 1;
        a_mready = 1'b0;
        set_req_a(0, 1'b0, 32'h500, 32'h0, 4'd0);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); #1;
            chk("t5_hold_ready", a_ready, 0);
            chk("t5_hold_mv", a_mv, 0);
        end
        rst_a = 1'b1;
        run_a(1, 20);
        chk("t5_first_after_rst", order_q[$], 0);
        run_a(1, 20);
        chk("t5_second_after_rst", order_q[$], 1);

        // Randomized traffic, then drain
        rnd_mode = 1;
        for (int s = 0; s < 400; s++) step_a();
        rnd_mode = 0;
        for (int s = 0; s < 100; s++) begin
            if (a_valid == 2'b00 && prev_idle && !exp_resp) break;
            step_a();
        end
        chk("t6_drained", {a_valid, prev_idle}, 3'b001);

        // Fixed priority: requester 0 wins while it keeps requesting
        for (int i = 0; i < 4; i++) begin
            b_addr[i*32 +: 32] = 32'h1000 + 32'(4 * i);
            b_wdata[i*32 +: 32] = 32'h0;
        end
        b_valid = 4'hF;
        for (int s = 0; s < 60 && b_grants < 5; s++) step_b(1);
        chk("b_grants", b_grants, 5);
        chk("b_last0", b_last, 0);
        b_valid = 4'hE;
        g0 = b_grants;
        for (int s = 0; s < 20 && b_grants == g0; s++) step_b(1);
        chk("b_next_lowest", b_last, 1);
        // Watchdog disabled: the port waits indefinitely for ready
        g0 = b_grants;
        for (int s = 0; s < 40; s++) step_b(0);
        chk("b_no_timeout_mv", b_mv, 1);
        chk("b_no_timeout_grants", b_grants, g0);
        for (int s = 0; s < 10 && b_grants == g0; s++) step_b(1);
        chk("b_late_done", b_grants, g0 + 1);
        b_valid = 4'h0;
        repeat (3) step_b(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
